// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: stage enables, flush/NOP
// injection, decode-stage forwarding selects, halt drain and a saturating bubble counter.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic             id_halt,
    input  logic [2:0]       ex_wr_reg,
    input  logic [2:0]       mem_wr_reg,
    input  logic             ex_reg_wrt,
    input  logic             mem_reg_wrt,
    input  logic             ex_mem_rd,
    input  logic             ex_redirect,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_nop,
    output logic             EXFWD1_D,
    output logic             EXFWD2_D,
    output logic             MEMFWD1_D,
    output logic             MEMFWD2_D,
    output logic             halted,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES);

    state_t     state;
    logic [1:0] dcnt;

    logic hx1, hx2, hm1, hm2, lu;
    logic halt_go;

    assign hx1 = id_rs_vld & ex_reg_wrt  & (ex_wr_reg  == id_rs);
    assign hx2 = id_rt_vld & ex_reg_wrt  & (ex_wr_reg  == id_rt);
    assign hm1 = id_rs_vld & mem_reg_wrt & (mem_wr_reg == id_rs);
    assign hm2 = id_rt_vld & mem_reg_wrt & (mem_wr_reg == id_rt);
    assign lu  = ex_mem_rd & (hx1 | hx2);

    // A load in EX cannot forward yet; the stall lets it reach MEM first.
    assign EXFWD1_D  = hx1 & ~ex_mem_rd;
    assign EXFWD2_D  = hx2 & ~ex_mem_rd;
    assign MEMFWD1_D = hm1 & ~hx1;
    assign MEMFWD2_D = hm2 & ~hx2;

    assign halted = (state == HALTED);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_nop   = 1'b0;
        halt_go    = 1'b0;
        unique case (state)
            RUN: begin
                if (dmem_stall) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                end else if (ex_redirect) begin
                    ifid_flush = 1'b1;
                    idex_nop   = 1'b1;
                end else if (lu) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_nop = 1'b1;
                end else if (imem_stall) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end else if (id_halt) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    halt_go = 1'b1;
                end
            end
            DRAIN: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_nop = 1'b1;
                if (dmem_stall) begin
                    {idex_en, exmem_en, memwb_en} = '0;
                end
            end
            default: begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            dcnt       <= '0;
            bubble_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (halt_go) begin
                        state <= DRAIN;
                        dcnt  <= DRAIN_INIT;
                    end
                    if ((idex_nop | ifid_flush) && !dmem_stall && (bubble_cnt != '1)) begin
                        bubble_cnt <= bubble_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!dmem_stall) begin
                        dcnt <= dcnt - 2'd1;
                        if (dcnt == 2'd1) begin
                            state <= HALTED;
                        end
                    end
                end
                default: begin
                    state <= HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, priorities, halt drain, reset and
// bubble counter saturation, with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_wr_reg, mem_wr_reg;
    logic        id_rs_vld, id_rt_vld, id_halt;
    logic        ex_reg_wrt, mem_reg_wrt, ex_mem_rd, ex_redirect;
    logic        imem_stall, dmem_stall;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_nop;
    logic        EXFWD1_D, EXFWD2_D, MEMFWD1_D, MEMFWD2_D;
    logic        halted;
    logic [15:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .id_halt(id_halt),
        .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg),
        .ex_reg_wrt(ex_reg_wrt), .mem_reg_wrt(mem_reg_wrt),
        .ex_mem_rd(ex_mem_rd), .ex_redirect(ex_redirect),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_nop(idex_nop),
        .EXFWD1_D(EXFWD1_D), .EXFWD2_D(EXFWD2_D),
        .MEMFWD1_D(MEMFWD1_D), .MEMFWD2_D(MEMFWD2_D),
        .halted(halted), .bubble_cnt(bubble_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 3'd0; id_rt = 3'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0; id_halt = 1'b0;
        ex_wr_reg = 3'd0; mem_wr_reg = 3'd0; ex_reg_wrt = 1'b0; mem_reg_wrt = 1'b0;
        ex_mem_rd = 1'b0; ex_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;
    endtask

    function automatic logic [4:0] ens();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        #12;
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_cnt", 32'(bubble_cnt), 32'd0);
        check("reset_ens_run", 32'(ens()), 32'h1F);
        rst = 1'b0;
        step();

        // Load-use: one bubble, then MEM forwarding with no stall.
        ex_mem_rd = 1'b1; ex_wr_reg = 3'd3; ex_reg_wrt = 1'b1; id_rs = 3'd3; id_rs_vld = 1'b1;
        #1;
        check("lu_ens", 32'(ens()), 32'b00111);
        check("lu_nop", 32'(idex_nop), 32'd1);
        check("lu_exfwd1", 32'(EXFWD1_D), 32'd0);
        step();
        check("lu_cnt", 32'(bubble_cnt), 32'd1);
        ex_mem_rd = 1'b0; ex_reg_wrt = 1'b0; mem_wr_reg = 3'd3; mem_reg_wrt = 1'b1;
        #1;
        check("lu_memfwd1", 32'(MEMFWD1_D), 32'd1);
        check("lu_next_ens", 32'(ens()), 32'h1F);
        check("lu_next_nop", 32'(idex_nop), 32'd0);
        step();
        check("lu_next_cnt", 32'(bubble_cnt), 32'd1);

        // Double forwarding on rt: EX wins over MEM.
        clear_inputs();
        ex_wr_reg = 3'd5; mem_wr_reg = 3'd5; ex_reg_wrt = 1'b1; mem_reg_wrt = 1'b1;
        id_rt = 3'd5; id_rt_vld = 1'b1;
        #1;
        check("dfwd_ex2", 32'(EXFWD2_D), 32'd1);
        check("dfwd_mem2", 32'(MEMFWD2_D), 32'd0);
        check("dfwd_ex1", 32'(EXFWD1_D), 32'd0);
        step();

        // Redirect beats load-use.
        clear_inputs();
        ex_mem_rd = 1'b1; ex_wr_reg = 3'd2; ex_reg_wrt = 1'b1; id_rs = 3'd2; id_rs_vld = 1'b1;
        ex_redirect = 1'b1;
        #1;
        check("redir_ens", 32'(ens()), 32'h1F);
        check("redir_flush", 32'(ifid_flush), 32'd1);
        check("redir_nop", 32'(idex_nop), 32'd1);
        step();
        check("redir_cnt", 32'(bubble_cnt), 32'd2);

        // dmem_stall beats redirect and injects no bubble.
        dmem_stall = 1'b1;
        #1;
        check("dstall_ens", 32'(ens()), 32'd0);
        check("dstall_flush", 32'(ifid_flush), 32'd0);
        step();
        check("dstall_cnt", 32'(bubble_cnt), 32'd2);

        // imem_stall alone: one IF/ID bubble.
        clear_inputs();
        imem_stall = 1'b1;
        #1;
        check("istall_ens", 32'(ens()), 32'b01111);
        check("istall_flush", 32'(ifid_flush), 32'd1);
        step();
        check("istall_cnt", 32'(bubble_cnt), 32'd3);

        // Halt drain with one stalled DRAIN cycle.
        clear_inputs();
        id_halt = 1'b1;
        #1;
        check("halt_ens", 32'(ens()), 32'b00111);
        check("halt_nop", 32'(idex_nop), 32'd0);
        step();                                   // H+1: DRAIN, dcnt=3
        clear_inputs();
        ex_redirect = 1'b1; imem_stall = 1'b1;
        #1;
        check("drain_ens", 32'(ens()), 32'b00111);
        check("drain_flush", 32'(ifid_flush), 32'd0);
        check("drain_nop", 32'(idex_nop), 32'd1);
        step();                                   // H+2: stalled, dcnt held at 2
        clear_inputs();
        dmem_stall = 1'b1;
        #1;
        check("drain_stall_ens", 32'(ens()), 32'd0);
        step();                                   // H+3
        clear_inputs();
        step();                                   // H+4
        check("drain_not_yet", 32'(halted), 32'd0);
        step();                                   // H+5
        check("halted_rise", 32'(halted), 32'd1);
        imem_stall = 1'b1; ex_redirect = 1'b1;
        #1;
        check("halted_ens", 32'(ens()), 32'd0);
        check("halted_flush_nop", 32'({ifid_flush, idex_nop}), 32'd0);
        repeat (3) step();
        check("halted_stays", 32'(halted), 32'd1);
        check("halted_cnt", 32'(bubble_cnt), 32'd3);

        // Asynchronous reset out of HALTED.
        clear_inputs();
        rst = 1'b1;
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cnt", 32'(bubble_cnt), 32'd0);
        check("rst_ens", 32'(ens()), 32'h1F);
        step();
        rst = 1'b0;
        step();
        check("run_after_rst", 32'(halted), 32'd0);

        // Saturation via sustained imem_stall.
        imem_stall = 1'b1;
        repeat (65534) step();
        check("sat_fffe", 32'(bubble_cnt), 32'hFFFE);
        step();
        check("sat_ffff", 32'(bubble_cnt), 32'hFFFF);
        repeat (3) step();
        check("sat_hold", 32'(bubble_cnt), 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
